string_hw_avalon_master: RTL and testbench

- Avalon-MM initiator that drives the String HW accelerator's slave register map from the host-logic side.
- Holds a local copy of StringA/StringB, writes both into the accelerator, then writes the Control register with go, index and length.
- Polls Control until done, clears go, and returns the final Control word to the requester.
- Sits between a local command source (custom logic or a test sequencer) and the accelerator's Avalon slave port.

---
 rtl/string_hw_avalon_master.sv | 178 +++++++++++++++++
 tb/tb_string_hw_avalon_master.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/string_hw_avalon_master.sv
// Avalon-MM initiator for the String HW accelerator: pushes StringA/StringB,
// starts the operation, polls Control until done (or timeout), then drops go.
`timescale 1ns/1ps

module string_hw_avalon_master #(
    parameter int MAX_WORDS    = 8,
    parameter int ADDR_W       = 5,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ld_we,
    input  logic                         ld_sel,
    input  logic [$clog2(MAX_WORDS)-1:0] ld_idx,
    input  logic [31:0]                  ld_data,
    input  logic                         start,
    input  logic [3:0]                   index,
    input  logic [7:0]                   length,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [31:0]                  status,
    output logic [ADDR_W-1:0]            avm_address,
    output logic                         avm_chipselect,
    output logic                         avm_read,
    output logic                         avm_write,
    output logic [31:0]                  avm_writedata,
    input  logic [31:0]                  avm_readdata
);

    localparam int IDX_W = $clog2(MAX_WORDS);
    localparam int PC_W  = $clog2(TIMEOUT + 1);
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(MAX_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE, WR_A, WR_B, WR_GO, POLL_RD, POLL_WAIT, WR_CLR, FIN
    } state_t;

    state_t            state;
    logic [31:0]       a_buf [MAX_WORDS];
    logic [31:0]       b_buf [MAX_WORDS];
    logic [IDX_W-1:0]  k;
    logic [PC_W-1:0]   poll_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [3:0]        idx_q;
    logic [7:0]        len_q;
    logic [31:0]       ctl_rd;
    logic              to_flag;
    logic [31:0]       a0_fwd;

    // A word loaded in the start cycle must reach the bus on the very next cycle.
    assign a0_fwd = (ld_we && !ld_sel && ld_idx == '0) ? ld_data : a_buf[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            k              <= '0;
            poll_cnt       <= '0;
            lat_cnt        <= '0;
            idx_q          <= '0;
            len_q          <= '0;
            ctl_rd         <= '0;
            to_flag        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            status         <= '0;
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            for (int i = 0; i < MAX_WORDS; i++) begin
                a_buf[i] <= '0;
                b_buf[i] <= '0;
            end
        end else begin
            // Strobes are single-cycle; each state re-arms the next one explicitly.
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            done           <= 1'b0;
            err            <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld_we) begin
                        if (ld_sel) b_buf[ld_idx] <= ld_data;
                        else        a_buf[ld_idx] <= ld_data;
                    end
                    if (start) begin
                        idx_q          <= index;
                        len_q          <= length;
                        busy           <= 1'b1;
                        k              <= '0;
                        poll_cnt       <= '0;
                        to_flag        <= 1'b0;
                        state          <= WR_A;
                        avm_write      <= 1'b1;
                        avm_chipselect <= 1'b1;
                        avm_address    <= ADDR_W'(1);
                        avm_writedata  <= a0_fwd;
                    end
                end
                WR_A: begin
                    avm_write      <= 1'b1;
                    avm_chipselect <= 1'b1;
                    if (k == LAST) begin
                        state         <= WR_B;
                        k             <= '0;
                        avm_address   <= ADDR_W'(MAX_WORDS + 1);
                        avm_writedata <= b_buf[0];
                    end else begin
                        k             <= k + 1'b1;
                        avm_address   <= ADDR_W'(k) + ADDR_W'(2);
                        avm_writedata <= a_buf[k + 1'b1];
                    end
                end
                WR_B: begin
                    avm_write      <= 1'b1;
                    avm_chipselect <= 1'b1;
                    if (k == LAST) begin
                        state         <= WR_GO;
                        k             <= '0;
                        avm_address   <= '0;
                        avm_writedata <= {18'b0, len_q, idx_q, 2'b10};
                    end else begin
                        k             <= k + 1'b1;
                        avm_address   <= ADDR_W'(k) + ADDR_W'(MAX_WORDS + 2);
                        avm_writedata <= b_buf[k + 1'b1];
                    end
                end
                WR_GO: begin
                    state          <= POLL_RD;
                    avm_read       <= 1'b1;
                    avm_chipselect <= 1'b1;
                end
                POLL_RD: begin
                    poll_cnt <= poll_cnt + 1'b1;
                    lat_cnt  <= '0;
                    state    <= POLL_WAIT;
                end
                POLL_WAIT: begin
                    if (lat_cnt == LAT_W'(READ_LATENCY - 1)) begin
                        ctl_rd <= avm_readdata;
                        if (avm_readdata[0] || poll_cnt == PC_W'(TIMEOUT)) begin
                            to_flag        <= ~avm_readdata[0];
                            state          <= WR_CLR;
                            avm_write      <= 1'b1;
                            avm_chipselect <= 1'b1;
                            avm_writedata  <= {18'b0, len_q, idx_q, 2'b00};
                        end else begin
                            state          <= POLL_RD;
                            avm_read       <= 1'b1;
                            avm_chipselect <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                WR_CLR: begin
                    state  <= FIN;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    err    <= to_flag;
                    status <= ctl_rd;
                end
                FIN: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_string_hw_avalon_master.sv
// Bench for string_hw_avalon_master: two instances (long and short timeout),
// behavioural slave per instance, bus trace compared against an expected transaction list.
`timescale 1ns/1ps

module tb_string_hw_avalon_master;

    localparam int MW  = 8;
    localparam int AW  = 5;
    localparam int RL  = 1;
    localparam int TO0 = 8;
    localparam int TO1 = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_we = 1'b0;
    logic        ld_sel = 1'b0;
    logic [2:0]  ld_idx = '0;
    logic [31:0] ld_data = '0;
    logic        start = 1'b0;
    logic [3:0]  index = '0;
    logic [7:0]  length = '0;
    int          tgt = 0;

    logic          busy_a [2];
    logic          done_a [2];
    logic          err_a  [2];
    logic          cs_a   [2];
    logic          rd_a   [2];
    logic          wr_a   [2];
    logic [31:0]   status_a [2];
    logic [31:0]   wdata_a  [2];
    logic [AW-1:0] addr_a   [2];

    int da [2] = '{0, 0};
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int          inst;
        bit          rd;
        int          addr;
        logic [31:0] data;
        int          cyc;
    } txn_t;
    txn_t act_q [$];

    logic [31:0] ma [MW];
    logic [31:0] mb [MW];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] rdq = '0;
        logic [31:0] ctl = '0;
        int          nrd = 0;
        logic        st;
        assign st = start && (tgt == g);

        string_hw_avalon_master #(
            .MAX_WORDS(MW), .ADDR_W(AW), .READ_LATENCY(RL), .TIMEOUT(g == 0 ? TO0 : TO1)
        ) u_dut (
            .clk(clk), .reset(reset), .ld_we(ld_we), .ld_sel(ld_sel), .ld_idx(ld_idx),
            .ld_data(ld_data), .start(st), .index(index), .length(length),
            .busy(busy_a[g]), .done(done_a[g]), .err(err_a[g]), .status(status_a[g]),
            .avm_address(addr_a[g]), .avm_chipselect(cs_a[g]), .avm_read(rd_a[g]),
            .avm_write(wr_a[g]), .avm_writedata(wdata_a[g]), .avm_readdata(rdq)
        );

        // Slave: remembers the last go write, reports done from the da-th poll on.
        always @(posedge clk) begin
            if (wr_a[g] && addr_a[g] == '0 && wdata_a[g][1]) begin
                ctl <= wdata_a[g];
                nrd <= 0;
            end
            if (rd_a[g]) begin
                nrd <= nrd + 1;
                rdq <= {ctl[31:1], (da[g] != 0 && nrd + 1 >= da[g])};
            end else begin
                rdq <= $urandom;
            end
        end

        always @(negedge clk) begin
            if (rd_a[g] || wr_a[g])
                act_q.push_back('{g, rd_a[g], int'(addr_a[g]), wdata_a[g], cyc});
            check($sformatf("rw_excl%0d", g), 32'(rd_a[g] & wr_a[g]), 32'd0);
            check($sformatf("cs%0d", g), 32'(cs_a[g]), 32'(rd_a[g] | wr_a[g]));
            if (!(rd_a[g] || wr_a[g])) begin
                check($sformatf("idle_addr%0d", g), 32'(addr_a[g]), 32'd0);
                check($sformatf("idle_wdata%0d", g), wdata_a[g], 32'd0);
            end
        end
    end

    function automatic logic [31:0] go_word(int idx, int len);
        return 32'(len * 64 + idx * 4 + 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(bit sel, int idx, logic [31:0] d);
        ld_we = 1'b1; ld_sel = sel; ld_idx = 3'(idx); ld_data = d;
        tick();
        ld_we = 1'b0;
        if (sel) mb[idx] = d; else ma[idx] = d;
    endtask

    task automatic launch(int inst, int idx, int len, int dafter,
                          bit do_ld, bit sel, int lidx, logic [31:0] ldat);
        tgt = inst; da[inst] = dafter;
        index = 4'(idx); length = 8'(len); start = 1'b1;
        if (do_ld) begin
            ld_we = 1'b1; ld_sel = sel; ld_idx = 3'(lidx); ld_data = ldat;
            if (sel) mb[lidx] = ldat; else ma[lidx] = ldat;
        end
        tick();
        start = 1'b0; ld_we = 1'b0;
        check("busy_rise", 32'(busy_a[inst]), 32'd1);
        check("no_early_done", 32'(done_a[inst]), 32'd0);
    endtask

    task automatic check_run(int inst, int idx, int len, int dafter);
        int          to;
        int          n;
        int          nexp;
        int          base;
        int          off;
        int          ea;
        bit          erd;
        bit          e_err;
        bit          ok;
        logic [31:0] ed;
        txn_t        t [$];
        to = inst ? TO1 : TO0;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (done_a[inst]) ok = 1'b1;
        end
        check("done_seen", 32'(ok), 32'd1);
        e_err = (dafter == 0 || dafter > to);
        n = e_err ? to : dafter;
        nexp = 2 * MW + 2 + n;
        foreach (act_q[i]) if (act_q[i].inst == inst) t.push_back(act_q[i]);
        act_q.delete();
        check("trace_len", 32'(t.size()), 32'(nexp));
        base = (t.size() > 0) ? t[0].cyc : 0;
        for (int i = 0; i < t.size() && i < nexp; i++) begin
            ed = '0;
            if (i < MW) begin
                erd = 0; ea = 1 + i; ed = ma[i]; off = i;
            end else if (i < 2 * MW) begin
                erd = 0; ea = 1 + i; ed = mb[i - MW]; off = i;
            end else if (i == 2 * MW) begin
                erd = 0; ea = 0; ed = go_word(idx, len); off = i;
            end else if (i < 2 * MW + 1 + n) begin
                erd = 1; ea = 0; off = 2 * MW + 1 + (i - 2 * MW - 1) * (RL + 1);
            end else begin
                erd = 0; ea = 0; ed = go_word(idx, len) - 32'd2; off = 2 * MW + 1 + n * (RL + 1);
            end
            check($sformatf("txn%0d_kind", i), 32'(t[i].rd), 32'(erd));
            check($sformatf("txn%0d_addr", i), 32'(t[i].addr), 32'(ea));
            check($sformatf("txn%0d_cyc", i), 32'(t[i].cyc - base), 32'(off));
            if (!erd) check($sformatf("txn%0d_data", i), t[i].data, ed);
        end
        if (ok) begin
            check("done_lat", 32'(cyc - base), 32'(2 * MW + 2 + n * (RL + 1)));
            check("err", 32'(err_a[inst]), 32'(e_err));
            check("status", status_a[inst], go_word(idx, len) | 32'(!e_err));
            check("busy_fin", 32'(busy_a[inst]), 32'd0);
        end
    endtask

    initial begin
        bit          seen;
        int          cnt;
        int          ri;
        int          rl;
        int          rd;
        logic [31:0] st_old;

        for (int i = 0; i < MW; i++) begin ma[i] = '0; mb[i] = '0; end
        repeat (3) tick();
        reset = 1'b0;
        for (int g = 0; g < 2; g++) begin
            check("rst_busy", 32'(busy_a[g]), 32'd0);
            check("rst_done", 32'(done_a[g]), 32'd0);
            check("rst_err", 32'(err_a[g]), 32'd0);
            check("rst_status", status_a[g], 32'd0);
            check("rst_strobe", 32'({cs_a[g], rd_a[g], wr_a[g]}), 32'd0);
        end

        // Directed load + slave done on first poll
        for (int k = 0; k < MW; k++) begin
            load(0, k, 32'h41424300 + 32'(k));
            load(1, k, 32'h61626300 + 32'(k));
        end
        launch(0, 3, 20, 1, 0, 0, 0, '0);
        check_run(0, 3, 20, 1);
        @(negedge clk);
        check("done_pulse", 32'(done_a[0]), 32'd0);

        // Done on the fifth poll
        tick();
        launch(0, 5, 100, 5, 0, 0, 0, '0);
        check_run(0, 5, 100, 5);

        // Short-timeout instance: never done, then done exactly at the last poll
        tick();
        launch(1, 9, 7, 0, 0, 0, 0, '0);
        check_run(1, 9, 7, 0);
        tick();
        launch(1, 2, 250, TO1, 0, 0, 0, '0);
        check_run(1, 2, 250, TO1);

        // Random loads, random control fields, load in the same cycle as start
        for (int it = 0; it < 4; it++) begin
            tick();
            repeat (3) load(1'($urandom_range(0, 1)), $urandom_range(0, MW - 1), $urandom);
            ri = $urandom_range(0, 15);
            rl = $urandom_range(0, 255);
            rd = $urandom_range(1, TO0);
            if (it == 0)
                launch(0, ri, rl, rd, 1, 0, 0, $urandom);
            else
                launch(0, ri, rl, rd, 1, 1'($urandom_range(0, 1)), $urandom_range(0, MW - 1), $urandom);
            check_run(0, ri, rl, rd);
        end

        // start/ld_we during WR_A are ignored
        tick();
        launch(0, 2, 33, 2, 0, 0, 0, '0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (wr_a[0] && addr_a[0] == 5'd5) seen = 1'b1;
        end
        check("reach_wa5", 32'(seen), 32'd1);
        start = 1'b1; ld_we = 1'b1; ld_sel = 1'b0; ld_idx = 3'd7; ld_data = ~ma[7];
        tick();
        start = 1'b0; ld_sel = 1'b1; ld_idx = 3'd0; ld_data = ~mb[0];
        tick();
        ld_we = 1'b0;
        check_run(0, 2, 33, 2);

        // Reset during WR_B k=3
        tick();
        launch(0, 1, 50, 1, 0, 0, 0, '0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (wr_a[0] && addr_a[0] == 5'(MW + 4)) seen = 1'b1;
        end
        check("reach_wb3", 32'(seen), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_strobe", 32'({cs_a[0], rd_a[0], wr_a[0]}), 32'd0);
        check("mid_rst_busy", 32'(busy_a[0]), 32'd0);
        check("mid_rst_done", 32'(done_a[0]), 32'd0);
        act_q.delete();
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_a[0]) cnt++;
        end
        check("mid_rst_no_done", 32'(cnt), 32'd0);
        check("mid_rst_no_txn", 32'(act_q.size()), 32'd0);
        for (int i = 0; i < MW; i++) begin ma[i] = '0; mb[i] = '0; end
        tick();
        launch(0, 6, 77, 1, 0, 0, 0, '0);
        check_run(0, 6, 77, 1);

        // Back-to-back: start in the cycle right after FIN
        tick();
        launch(0, 4, 10, 1, 0, 0, 0, '0);
        check_run(0, 4, 10, 1);
        st_old = go_word(4, 10) | 32'd1;
        tick();
        launch(0, 7, 200, 2, 0, 0, 0, '0);
        repeat (5) @(negedge clk);
        check("status_hold", status_a[0], st_old);
        check_run(0, 7, 200, 2);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
